// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and its width.
package pll_sup_pkg;

    localparam int unsigned StateW = 3;

    typedef enum logic [StateW-1:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFault     = 3'd4
    } state_e;

endpackage

// File: rtl/pll_sup_sync.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module pll_sup_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer on refclk: timed PLL reset, lock wait with retry,
// lock debounce, registered ready flag, sticky fault and lock-loss statistics.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 17
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              restart,
    output logic              pll_rst,
    output logic              ready,
    output logic              fault,
    output logic              lock_lost,
    output logic [3:0]        retry_cnt,
    output logic [7:0]        loss_cnt,
    output logic [StateW-1:0] state_o
);

    localparam logic [CNT_W-1:0] RstLast     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]       RetryLimit  = 4'(MAX_RETRIES);

    logic locked_s;

    pll_sup_sync u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    state_e     state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [3:0] retry_d, retry_q;
    logic [7:0] loss_d, loss_q;
    logic       lost_d, lost_q;
    logic       pll_rst_d, pll_rst_q;
    logic       ready_d, ready_q;
    logic       fault_d, fault_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        lost_d  = 1'b0;

        if (restart) begin
            state_d = StResetPll;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (cnt_q == RstLast) begin
                        cnt_d   = '0;
                        state_d = StWaitLock;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    // A lock seen on the timeout cycle still wins.
                    if (locked_s) begin
                        cnt_d   = '0;
                        state_d = StStabilize;
                    end else if (cnt_q == TimeoutLast) begin
                        cnt_d = '0;
                        if (retry_q == RetryLimit) begin
                            state_d = StFault;
                        end else begin
                            retry_d = retry_q + 4'd1;
                            state_d = StResetPll;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStabilize: begin
                    if (!locked_s) begin
                        cnt_d   = '0;
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        lost_d  = 1'b1;
                        loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                        retry_d = '0;
                        cnt_d   = '0;
                        state_d = StResetPll;
                    end
                end
                StFault: begin
                    cnt_d = '0;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = StResetPll;
                end
            endcase
        end

        // Flags are decoded from the next state so they change on the same edge as state.
        ready_d   = (state_d == StRun);
        fault_d   = (state_d == StFault);
        pll_rst_d = (state_d == StResetPll) || (state_d == StFault);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= StResetPll;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign lock_lost = lost_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench: countdown-based reference model compared every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_pll_lock_supervisor;

    localparam int unsigned RST_CYCLES   = 4;
    localparam int unsigned LOCK_STABLE  = 8;
    localparam int unsigned LOCK_TIMEOUT = 32;
    localparam int unsigned MAX_RETRIES  = 2;
    localparam int unsigned CNT_W        = 17;

    localparam int PReset = 0, PWait = 1, PStab = 2, PRun = 3, PFault = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, ready, fault, lock_lost;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state_o;

    int  n_checks = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRIES  (MAX_RETRIES),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .restart    (restart),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fault      (fault),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt),
        .state_o    (state_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each phase has a duration loaded on entry and counted down.
    int m_phase, m_left, m_retry, m_loss;
    bit m_lost, m_s1, m_s2;

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_phase <= PReset; m_left <= RST_CYCLES; m_retry <= 0; m_loss <= 0;
            m_lost <= 1'b0; m_s1 <= 1'b0; m_s2 <= 1'b0;
        end else begin
            m_s1   <= pll_locked;
            m_s2   <= m_s1;
            m_lost <= 1'b0;
            if (restart) begin
                m_phase <= PReset; m_left <= RST_CYCLES; m_retry <= 0;
            end else begin
                case (m_phase)
                    PReset:
                        if (m_left == 1) begin m_phase <= PWait; m_left <= LOCK_TIMEOUT; end
                        else m_left <= m_left - 1;
                    PWait:
                        if (m_s2) begin m_phase <= PStab; m_left <= LOCK_STABLE; end
                        else if (m_left == 1) begin
                            if (m_retry == MAX_RETRIES) m_phase <= PFault;
                            else begin
                                m_retry <= m_retry + 1; m_phase <= PReset; m_left <= RST_CYCLES;
                            end
                        end else m_left <= m_left - 1;
                    PStab:
                        if (!m_s2) begin m_phase <= PWait; m_left <= LOCK_TIMEOUT; end
                        else if (m_left == 1) m_phase <= PRun;
                        else m_left <= m_left - 1;
                    PRun:
                        if (!m_s2) begin
                            m_lost  <= 1'b1;
                            m_loss  <= (m_loss < 255) ? m_loss + 1 : 255;
                            m_retry <= 0;
                            m_phase <= PReset; m_left <= RST_CYCLES;
                        end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge refclk) begin
        if (chk_en) begin
            check("state_o",   int'(state_o),   m_phase);
            check("ready",     int'(ready),     int'(m_phase == PRun));
            check("fault",     int'(fault),     int'(m_phase == PFault));
            check("pll_rst",   int'(pll_rst),   int'(m_phase == PReset || m_phase == PFault));
            check("lock_lost", int'(lock_lost), int'(m_lost));
            check("retry_cnt", int'(retry_cnt), m_retry);
            check("loss_cnt",  int'(loss_cnt),  m_loss);
        end
    end

    task automatic wait_ready(input logic lvl, input int budget, output int k);
        k = 0;
        do begin
            @(negedge refclk);
            k++;
        end while (ready !== lvl && k < budget);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},   int'(state_o),   0);
        check({tag, "_pll_rst"}, int'(pll_rst),   1);
        check({tag, "_ready"},   int'(ready),     0);
        check({tag, "_fault"},   int'(fault),     0);
        check({tag, "_lost"},    int'(lock_lost), 0);
        check({tag, "_retry"},   int'(retry_cnt), 0);
        check({tag, "_loss"},    int'(loss_cnt),  0);
    endtask

    initial begin
        int k, n_hi, n_lo, n_lost, n_to, max_retry;
        #1 rst = 1'b1;
        @(negedge refclk);
        check_reset_values("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // Power-up: pll_rst held for RST_CYCLES, lock applied 10 cycles after release.
        n_hi = int'(pll_rst);
        for (int i = 0; i < 10; i++) begin
            @(negedge refclk);
            n_hi += int'(pll_rst);
        end
        check("t1_pll_rst_cycles", n_hi, 4);
        pll_locked = 1'b1;
        wait_ready(1'b1, 100, k);
        // 2 sync edges + 1 detect edge + 8 debounce edges after the change.
        check("t1_ready_latency", k, 11);
        check("t1_fault", int'(fault), 0);
        check("t1_retry", int'(retry_cnt), 0);

        // Lock drops in RUN for 5 cycles.
        repeat (3) @(negedge refclk);
        pll_locked = 1'b0;
        n_lost = 0; n_hi = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge refclk);
            if (i == 5) pll_locked = 1'b1;
            n_lost += int'(lock_lost);
            n_hi   += int'(pll_rst);
        end
        check("t4_lost_pulses", n_lost, 1);
        check("t4_pll_rst_cycles", n_hi, 4);
        check("t4_loss_cnt", int'(loss_cnt), 1);
        check("t4_reacquired", int'(ready), 1);

        // Restart from RUN, then drop lock at debounce count 5.
        restart = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        check("t5_no_lost_on_restart", int'(lock_lost), 0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge refclk);
            if (i == 8) pll_locked = 1'b0;
            if (i == 10) check("t5_in_stabilize", int'(state_o), PStab);
            if (i == 11) begin
                check("t5_back_to_wait", int'(state_o), PWait);
                check("t5_retry_unchanged", int'(retry_cnt), 0);
            end
        end
        pll_locked = 1'b1;
        wait_ready(1'b1, 100, k);
        check("t5_fresh_debounce", k, 11);

        // Restart with lock held low: three attempts then FAULT.
        restart = 1'b1;
        pll_locked = 1'b0;
        @(negedge refclk);
        restart = 1'b0;
        k = 0; n_lo = 0; max_retry = 0;
        while (fault !== 1'b1 && k < 300) begin
            n_lo += int'(!pll_rst);
            if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
            @(negedge refclk);
            k++;
        end
        check("t2_fault_cycle", k, 3 * (RST_CYCLES + LOCK_TIMEOUT));
        check("t2_wait_cycles", n_lo, 3 * LOCK_TIMEOUT);
        check("t2_max_retry", max_retry, 2);
        repeat (20) @(negedge refclk);
        check("t2_fault_sticky", int'(fault), 1);
        check("t2_pll_rst_stuck", int'(pll_rst), 1);
        check("t2_state_fault", int'(state_o), PFault);

        // Restart out of FAULT with lock present.
        restart = 1'b1;
        pll_locked = 1'b1;
        @(negedge refclk);
        restart = 1'b0;
        check("t3_fault_cleared", int'(fault), 0);
        check("t3_retry_cleared", int'(retry_cnt), 0);
        wait_ready(1'b1, 100, k);
        check("t3_ready_cycle", k, 13);
        check("t3_loss_kept", int'(loss_cnt), 1);

        // Saturate the loss counter with single-cycle dropouts.
        n_to = 0;
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b0;
            @(negedge refclk);
            pll_locked = 1'b1;
            wait_ready(1'b0, 20, k);
            if (ready !== 1'b0) n_to++;
            wait_ready(1'b1, 60, k);
            if (ready !== 1'b1) n_to++;
        end
        check("t6_timeouts", n_to, 0);
        check("t6_loss_saturated", int'(loss_cnt), 255);

        // Asynchronous reset mid-RUN.
        repeat (3) @(negedge refclk);
        #2 rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge refclk);
        rst = 1'b0;
        repeat (30) @(negedge refclk);
        check("final_ready", int'(ready), 1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
